// File: rtl/hdmi_timing_pkg.sv
// Shared 640x480@60 raster constants and helpers for the HDMI read-side timing generator.
package hdmi_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF  = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned H_TOTAL_DEF   = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF  = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;
  localparam int unsigned V_TOTAL_DEF   = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned READ_LEAD_DEF = 4;
  localparam int unsigned OUT_LAT_DEF   = 3;

  // Control bundle carried through the delay lines; syncs stay active-low end to end.
  typedef struct packed {
    logic de;
    logic hsync_n;
    logic vsync_n;
  } video_ctl_t;

  localparam video_ctl_t CTL_IDLE = '{de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

  // Half-open window test [lo, hi) used for all raster decodes.
  function automatic logic in_range(input int unsigned value,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register pipeline with a programmable idle value and synchronous flush.
module delay_line
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned      WIDTH = 1,
  parameter int unsigned      DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  // Shift one stage per clock; a flush forces every stage back to idle so nothing stale drains out later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stages[i] <= INIT;
    end else if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) stages[i] <= INIT;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/hdmi_read_timing.sv
// Raster timing for the HDMI read path: frame-memory read strobes lead the
// pixel pipeline, and DE/syncs are realigned after the colour-conversion latency.
module hdmi_read_timing
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter int unsigned READ_LEAD = READ_LEAD_DEF,
  parameter int unsigned OUT_LAT   = OUT_LAT_DEF
) (
  input  logic Hclk,
  input  logic rstn,
  input  logic en,
  output logic HVsync,
  output logic HMemRead,
  output logic pVDE,
  output logic vde,
  output logic hsync,
  output logic vsync,
  output logic frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          hsync_raw_n;
  logic          vsync_raw_n;
  logic          flush;
  video_ctl_t    lead_ctl;
  video_ctl_t    out_ctl;

  assign flush = ~en;

  // Raster position: pixel counter wraps per line and steps the line counter; parked at origin while disabled.
  always_ff @(posedge Hclk or negedge rstn) begin
    if (!rstn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Decode the current raster position into read-side strobes and undelayed syncs.
  always_ff @(posedge Hclk or negedge rstn) begin
    if (!rstn) begin
      HVsync      <= 1'b0;
      HMemRead    <= 1'b0;
      hsync_raw_n <= 1'b1;
      vsync_raw_n <= 1'b1;
      frame_start <= 1'b0;
    end else if (!en) begin
      HVsync      <= 1'b0;
      HMemRead    <= 1'b0;
      hsync_raw_n <= 1'b1;
      vsync_raw_n <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      HVsync      <= in_range(32'(vcnt), 0, V_ACTIVE);
      HMemRead    <= in_range(32'(hcnt), 0, H_ACTIVE) && in_range(32'(vcnt), 0, V_ACTIVE);
      hsync_raw_n <= !in_range(32'(hcnt), HS_START, HS_END);
      vsync_raw_n <= !in_range(32'(vcnt), VS_START, VS_END);
      frame_start <= (hcnt == '0) && (vcnt == '0);
    end
  end

  // Cover the frame-memory latency: read strobe becomes pre-DE, syncs ride along.
  delay_line #(
    .WIDTH (3),
    .DEPTH (READ_LEAD),
    .INIT  (CTL_IDLE)
  ) u_lead_delay (
    .clk   (Hclk),
    .rst_n (rstn),
    .clr   (flush),
    .din   ({HMemRead, hsync_raw_n, vsync_raw_n}),
    .dout  (lead_ctl)
  );

  // Cover the colour-conversion latency so DE and syncs line up with the pixel data.
  delay_line #(
    .WIDTH (3),
    .DEPTH (OUT_LAT),
    .INIT  (CTL_IDLE)
  ) u_out_delay (
    .clk   (Hclk),
    .rst_n (rstn),
    .clr   (flush),
    .din   (lead_ctl),
    .dout  (out_ctl)
  );

  assign pVDE  = lead_ctl.de;
  assign vde   = out_ctl.de;
  assign hsync = out_ctl.hsync_n;
  assign vsync = out_ctl.vsync_n;

endmodule

// File: tb/tb_hdmi_read_timing.sv
// Bench for hdmi_read_timing: one default-size instance and one shrunken raster,
// both checked every cycle against a time-index model plus hand-computed pins.
module tb_hdmi_read_timing;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb, rl, ol;
  } timing_t;

  localparam timing_t D_CFG = '{ha: 640, hf: 16, hs: 96, hb: 48,
                                 va: 480, vf: 10, vs: 2, vb: 33, rl: 4, ol: 3};
  localparam timing_t S_CFG = '{ha: 8, hf: 2, hs: 3, hb: 2,
                                 va: 4, vf: 1, vs: 2, vb: 1, rl: 4, ol: 3};

  // Output vector order: {HVsync, HMemRead, pVDE, vde, hsync, vsync, frame_start}
  localparam logic [6:0] IDLE = 7'b0000110;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;

  logic dHVsync, dHMemRead, dPVDE, dVde, dHsync, dVsync, dFs;
  logic sHVsync, sHMemRead, sPVDE, sVde, sHsync, sVsync, sFs;
  logic [6:0] dOut, sOut;

  int nCompared = 0;
  int nMismatched = 0;
  int kCnt = 0;

  int dReadCnt, dPvdeFirst, dVdeFirst, dHsLowFirst, dHsLowCnt, dFsCnt;
  int sReadCnt, sHvCnt, sVsLowCnt, sFs1, sFs2;
  int dVdeAfterDrop, sVdeAfterDrop;
  int sPvdeFirst, sVdeFirst;

  always #5 clk = ~clk;

  hdmi_read_timing u_dut_default (
    .Hclk        (clk),
    .rstn        (rstn),
    .en          (en),
    .HVsync      (dHVsync),
    .HMemRead    (dHMemRead),
    .pVDE        (dPVDE),
    .vde         (dVde),
    .hsync       (dHsync),
    .vsync       (dVsync),
    .frame_start (dFs)
  );

  hdmi_read_timing #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .READ_LEAD (4), .OUT_LAT (3)
  ) u_dut_small (
    .Hclk        (clk),
    .rstn        (rstn),
    .en          (en),
    .HVsync      (sHVsync),
    .HMemRead    (sHMemRead),
    .pVDE        (sPVDE),
    .vde         (sVde),
    .hsync       (sHsync),
    .vsync       (sVsync),
    .frame_start (sFs)
  );

  assign dOut = {dHVsync, dHMemRead, dPVDE, dVde, dHsync, dVsync, dFs};
  assign sOut = {sHVsync, sHMemRead, sPVDE, sVde, sHsync, sVsync, sFs};

  // Number of consecutive edges that sampled en high since reset or the last en-low edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn)   kCnt <= 0;
    else if (en) kCnt <= kCnt + 1;
    else         kCnt <= 0;
  end

  function automatic int hTot(timing_t c);
    return c.ha + c.hf + c.hs + c.hb;
  endfunction

  function automatic int vTot(timing_t c);
    return c.va + c.vf + c.vs + c.vb;
  endfunction

  // Expected outputs after k enabled edges: position p = k-1 is the raster pixel
  // whose read strobe is showing; delayed signals look back rl / rl+ol pixels.
  function automatic logic [6:0] modelOut(int k, timing_t c);
    logic [6:0] r;
    int p, h, v;
    r = IDLE;
    if (k >= 1) begin
      p = k - 1;
      h = p % hTot(c);
      v = (p / hTot(c)) % vTot(c);
      r[6] = (v < c.va);
      r[5] = (v < c.va) && (h < c.ha);
      r[0] = (h == 0) && (v == 0);
    end
    if (k - c.rl >= 1) begin
      p = k - c.rl - 1;
      h = p % hTot(c);
      v = (p / hTot(c)) % vTot(c);
      r[4] = (v < c.va) && (h < c.ha);
    end
    if (k - c.rl - c.ol >= 1) begin
      p = k - c.rl - c.ol - 1;
      h = p % hTot(c);
      v = (p / hTot(c)) % vTot(c);
      r[3] = (v < c.va) && (h < c.ha);
      r[2] = !((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs));
      r[1] = !((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs));
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
               name, $time, actual, actual, expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic newRstn, input logic newEn);
    @(posedge clk);
    #2;
    rstn = newRstn;
    en   = newEn;
  endtask

  // Per-cycle scoreboard against the model for both raster sizes.
  always @(negedge clk) begin
    logic [6:0] dExp, sExp;
    dExp = modelOut(kCnt, D_CFG);
    sExp = modelOut(kCnt, S_CFG);
    nCompared += 2;
    if (dOut !== dExp) begin
      nMismatched++;
      $display("[TB] FAIL cycle_default at %0t k=%0d: got %b, expected %b", $time, kCnt, dOut, dExp);
    end
    if (sOut !== sExp) begin
      nMismatched++;
      $display("[TB] FAIL cycle_small at %0t k=%0d: got %b, expected %b", $time, kCnt, sOut, sExp);
    end
  end

  initial begin
    dReadCnt = 0; dPvdeFirst = 0; dVdeFirst = 0; dHsLowFirst = 0; dHsLowCnt = 0; dFsCnt = 0;
    sReadCnt = 0; sHvCnt = 0; sVsLowCnt = 0; sFs1 = 0; sFs2 = 0;
    dVdeAfterDrop = 0; sVdeAfterDrop = 0; sPvdeFirst = 0; sVdeFirst = 0;

    $display("[TB] reset and idle checks");
    repeat (3) @(negedge clk);
    checkOutput("reset_default", int'(dOut), int'(IDLE));
    checkOutput("reset_small", int'(sOut), int'(IDLE));

    applyStimulus(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("idle_no_en_default", int'(dOut), int'(IDLE));
    checkOutput("idle_no_en_small", int'(sOut), int'(IDLE));

    $display("[TB] first enable and frame run");
    applyStimulus(1'b1, 1'b1);
    @(posedge clk);
    for (int c = 1; c <= 1700; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("read_at_E0", int'(dHMemRead), 1);
        checkOutput("fs_at_E0", int'(dFs), 1);
      end
      if (c <= 800 && dHMemRead) dReadCnt++;
      if (dPVDE && dPvdeFirst == 0) dPvdeFirst = c;
      if (dVde && dVdeFirst == 0) dVdeFirst = c;
      if (!dHsync && dHsLowFirst == 0) dHsLowFirst = c;
      if (c <= 800 && !dHsync) dHsLowCnt++;
      if (dFs) dFsCnt++;
      if (c <= 120 && sHMemRead) sReadCnt++;
      if (c <= 120 && sHVsync) sHvCnt++;
      if (c <= 120 && !sVsync) sVsLowCnt++;
      if (sFs) begin
        if (sFs1 == 0) sFs1 = c;
        else if (sFs2 == 0) sFs2 = c;
      end
    end
    checkOutput("read_cycles_line0", dReadCnt, 640);
    checkOutput("pvde_first", dPvdeFirst, 5);
    checkOutput("vde_first", dVdeFirst, 8);
    checkOutput("hsync_low_first", dHsLowFirst, 664);
    checkOutput("hsync_low_len", dHsLowCnt, 96);
    checkOutput("fs_count_default", dFsCnt, 1);
    checkOutput("small_reads_per_frame", sReadCnt, 32);
    checkOutput("small_hvsync_per_frame", sHvCnt, 60);
    checkOutput("small_vsync_low", sVsLowCnt, 30);
    checkOutput("small_fs_first", sFs1, 1);
    checkOutput("small_fs_period", sFs2 - sFs1, 120);
    checkOutput("vde_before_drop", int'(dVde), 1);

    $display("[TB] enable dropped mid-line");
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("drop_default", int'(dOut), int'(IDLE));
    checkOutput("drop_small", int'(sOut), int'(IDLE));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dVde) dVdeAfterDrop++;
      if (sVde) sVdeAfterDrop++;
    end
    checkOutput("no_vde_after_drop_default", dVdeAfterDrop, 0);
    checkOutput("no_vde_after_drop_small", sVdeAfterDrop, 0);

    $display("[TB] re-enable");
    dPvdeFirst = 0; dVdeFirst = 0;
    applyStimulus(1'b1, 1'b1);
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("re_read_at_E0", int'(dHMemRead), 1);
        checkOutput("re_fs_at_E0", int'(sFs), 1);
      end
      if (dPVDE && dPvdeFirst == 0) dPvdeFirst = c;
      if (dVde && dVdeFirst == 0) dVdeFirst = c;
      if (sPVDE && sPvdeFirst == 0) sPvdeFirst = c;
      if (sVde && sVdeFirst == 0) sVdeFirst = c;
    end
    checkOutput("re_pvde_first", dPvdeFirst, 5);
    checkOutput("re_vde_first", dVdeFirst, 8);
    checkOutput("re_small_pvde_first", sPvdeFirst, 5);
    checkOutput("re_small_vde_first", sVdeFirst, 8);
    checkOutput("vde_before_rst", int'(dVde), 1);

    $display("[TB] asynchronous reset pulse between edges");
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_default", int'(dOut), int'(IDLE));
    checkOutput("async_rst_small", int'(sOut), int'(IDLE));
    #1;
    rstn = 1'b1;
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/hdmi_read_timing.md
HDMI_READ_TIMING -- requirements
Module: hdmi_read_timing

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- READ_LEAD, 4, cycles HMemRead leads pVDE (frame-memory read latency, >=1)
- OUT_LAT, 3, cycles pVDE leads vde/hsync/vsync (colour-conversion latency, >=1)

REQ-002 Ports SHALL be (name, direction, width, meaning):
- Hclk, in, 1, pixel clock
- rstn, in, 1, reset
- en, in, 1, timing enable
- HVsync, out, 1, high while the frame-memory read window is open; low resets the reader's address
- HMemRead, out, 1, per-pixel frame-memory read strobe
- pVDE, out, 1, pre-DE aligned with the read data
- vde, out, 1, final data enable aligned with HDMIdata
- hsync, out, 1, horizontal sync, active low
- vsync, out, 1, vertical sync, active low
- frame_start, out, 1, one-cycle pulse at the first pixel of each frame

REQ-003 One clock, Hclk; reset rstn is asynchronous and active-low.

Function
REQ-004 hcnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800) and wrap to 0.
REQ-005 vcnt SHALL increment when hcnt wraps, count 0..V_TOTAL-1 (525), and wrap to 0.
REQ-006 While en is sampled low, hcnt and vcnt SHALL be held at 0.
REQ-007 While en is sampled low, all outputs SHALL be deasserted (HVsync=0, HMemRead=0, pVDE=0, vde=0, hsync=1, vsync=1, frame_start=0) and every delay stage SHALL be cleared.
REQ-008 All outputs SHALL be registered, each decoded from (hcnt,vcnt) or taken from a delay line.
REQ-009 At the first edge where en is sampled high, HMemRead SHALL assert and the counters SHALL advance.
REQ-010 HMemRead SHALL be 1 exactly when hcnt<H_ACTIVE and vcnt<V_ACTIVE, giving 640 consecutive cycles per active line and 480 active lines per frame.
REQ-011 HVsync SHALL be 1 exactly when vcnt<V_ACTIVE, and 0 for all V_TOTAL-V_ACTIVE blanking lines.
REQ-012 frame_start SHALL be 1 for exactly one cycle, coincident with the first HMemRead of each frame.
REQ-013 pVDE SHALL equal HMemRead delayed by exactly READ_LEAD cycles.
REQ-014 vde SHALL equal pVDE delayed by exactly OUT_LAT cycles.
REQ-015 hsync SHALL be 0 for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and vsync SHALL be 0 for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-016 hsync and vsync SHALL both be delayed by READ_LEAD+OUT_LAT cycles so they stay aligned with vde.
REQ-017 If en falls mid-frame, counters SHALL return to 0 and outputs SHALL go to the REQ-007 values on the next edge; no partial line may emerge later from the delay lines.
REQ-018 If en rises again, a fresh frame SHALL start at (0,0) per REQ-009.
REQ-019 At the hcnt and vcnt wrap edge, vcnt SHALL wrap to 0 and frame_start SHALL fire on the same cycle HMemRead restarts.

Reset
REQ-020 On rstn low, hcnt=0, vcnt=0, all delay stages cleared, and outputs SHALL take the REQ-007 values immediately (asynchronous).
REQ-021 After rstn deasserts, operation SHALL begin only when en is sampled high.

Structure
REQ-022 Timing constants (H/V active, porch and sync defaults, H_TOTAL, V_TOTAL) SHALL live in shared package hdmi_timing_pkg.
REQ-023 Delays SHALL use one sub-module, delay_line (parameterised width and depth, async active-low reset, synchronous clear input), instantiated for pVDE and for the combined {vde,hsync,vsync} path.

Verification
REQ-024 Reset, then en=1 at edge E0: HMemRead=1 from E0 for 640 cycles; pVDE rises at E0+4; vde rises at E0+7; frame_start=1 only at E0.
REQ-025 Full frame: count HMemRead high cycles = 307200; HVsync high for 480*800 cycles; hsync low runs of 96 cycles starting 656 cycles after line start, +7 cycles output delay.
REQ-026 Frame wrap: vsync low for exactly 1600 cycles per frame; frame_start period = 420000 cycles.
REQ-027 en dropped at line 100, pixel 300: next edge HMemRead=pVDE=vde=0 and hsync=vsync=1; no vde pulse within the following 20 cycles.
REQ-028 Re-enable after REQ-027: timing identical to REQ-024.
REQ-029 Asynchronous rstn pulse mid-line between clock edges: outputs reach REQ-007 values before the next Hclk edge.
